// File: rtl/aes_encrypt_arbiter_if.sv
// aes_encrypt_arbiter_if: requester-side request/response bundle for the shared AES arbiter
interface aes_encrypt_arbiter_if #(parameter int N_REQ = 4);
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [128*N_REQ-1:0] req_data;
    logic [256*N_REQ-1:0] req_key;
    logic [2*N_REQ-1:0]   req_ksel;
    logic [N_REQ-1:0]     resp_valid;
    logic [N_REQ-1:0]     resp_ready;
    logic [127:0]         resp_data;
    logic                 resp_err;
    modport master(
        output req_valid, req_data, req_key, req_ksel, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );
    modport slave(
        input  req_valid, req_data, req_key, req_ksel, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/aes_encrypt_arbiter.sv
// aes_encrypt_arbiter: round-robin sharing of one AES encrypt datapath among N_REQ requesters
module aes_encrypt_arbiter #(
    parameter int N_REQ    = 4,
    parameter int CORE_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    aes_encrypt_arbiter_if.slave  bus,
    output logic [127:0]          o_core_in,
    output logic [255:0]          o_core_key,
    output logic [1:0]            o_core_ksel,
    input  logic [127:0]          i_core_out
);
    localparam int IW    = $clog2(N_REQ);
    localparam int CNT_W = $clog2(CORE_LAT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t             r_state, w_next;
    logic [IW-1:0]      r_rr_ptr, r_id, w_gnt;
    logic [CNT_W-1:0]   r_cnt;
    logic [127:0]       r_core_in, r_resp_data;
    logic [255:0]       r_core_key;
    logic [1:0]         r_core_ksel, w_ksel;
    logic               r_err, w_found, w_accept, w_illegal, w_hs;

    always_comb begin
        w_found = 1'b0;
        w_gnt = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && bus.req_valid[IW'((int'(r_rr_ptr) + k) % N_REQ)]) begin
                w_found = 1'b1;
                w_gnt = IW'((int'(r_rr_ptr) + k) % N_REQ);
            end
        end
    end

    assign w_ksel    = bus.req_ksel[2*w_gnt +: 2];
    assign w_illegal = (w_ksel == 2'd3);
    assign w_accept  = !rst && (r_state == IDLE) && w_found;
    assign w_hs      = (r_state == RESP) && bus.resp_ready[r_id];

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == IDLE) ? (w_accept ? (w_illegal ? RESP : BUSY) : IDLE)
               : (r_state == BUSY) ? ((r_cnt == '0) ? RESP : BUSY)
               : (r_state == RESP) ? (w_hs ? IDLE : RESP)
               : IDLE;
    end

    always_comb begin
        bus.req_ready = '0;
        bus.resp_valid = '0;
        bus.req_ready[w_gnt] = w_accept;
        bus.resp_valid[r_id] = (r_state == RESP);
    end

    // Illegal key sizes skip the core entirely, so core_* keep the previous job's values
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_id        <= '0;
            r_cnt       <= '0;
            r_core_in   <= '0;
            r_core_key  <= '0;
            r_core_ksel <= '0;
            r_resp_data <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_id     <= w_gnt;
                r_rr_ptr <= IW'((int'(w_gnt) + 1) % N_REQ);
                r_cnt    <= CNT_W'(CORE_LAT - 1);
                if (w_illegal) begin
                    r_err       <= 1'b1;
                    r_resp_data <= '0;
                end else begin
                    r_core_in   <= bus.req_data[128*w_gnt +: 128];
                    r_core_key  <= bus.req_key[256*w_gnt +: 256];
                    r_core_ksel <= w_ksel;
                end
            end
            if (r_state == BUSY) begin
                r_cnt <= r_cnt - 1'b1;
                if (r_cnt == '0) r_resp_data <= i_core_out;
            end
            if (w_hs) r_err <= 1'b0;
        end
    end

    assign bus.resp_data = r_resp_data;
    assign bus.resp_err  = r_err;
    assign o_core_in     = r_core_in;
    assign o_core_key    = r_core_key;
    assign o_core_ksel   = r_core_ksel;
endmodule

// File: tb/tb_aes_encrypt_arbiter.sv
// tb_aes_encrypt_arbiter: directed checks of arbitration, latency, handshake and reset behaviour
module tb_aes_encrypt_arbiter;
    localparam int N   = 4;
    localparam int LAT = 2;

    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K128  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [191:0] K192  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] core_in, core_out;
    logic [255:0] core_key;
    logic [1:0]   core_ksel;
    int           n_chk = 0;
    int           n_err = 0;

    aes_encrypt_arbiter_if #(.N_REQ(N)) bus();

    aes_encrypt_arbiter #(.N_REQ(N), .CORE_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .o_core_in(core_in), .o_core_key(core_key), .o_core_ksel(core_ksel),
        .i_core_out(core_out)
    );

    always #5 clk = ~clk;

    // Known AES vectors for the reference inputs; a fixed mix for any other input
    function automatic logic [127:0] core_model(input logic [127:0] d, input logic [255:0] k, input logic [1:0] s);
        if (s == 2'd0 && d == PT && k == {128'b0, K128}) return CT128;
        if (s == 2'd1 && d == PT && k == {64'b0, K192})  return CT192;
        if (s == 2'd2 && d == PT && k == K256)           return CT256;
        return d ^ k[127:0] ^ k[255:128] ^ {126'b0, s} ^ 128'h5a5a_5a5a_0000_ffff_1234_5678_9abc_def0;
    endfunction

    always_comb core_out = core_model(core_in, core_key, core_ksel);

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [127:0] d, input logic [255:0] k, input logic [1:0] s);
        bus.req_data[128*i +: 128] = d;
        bus.req_key[256*i +: 256]  = k;
        bus.req_ksel[2*i +: 2]     = s;
    endtask

    task automatic wait_ready(input int i);
        int w = 0;
        while (bus.req_ready[i] !== 1'b1 && w < 40) begin
            @(negedge clk); #1;
            w++;
        end
    endtask

    task automatic wait_any;
        int w = 0;
        while (bus.req_ready === '0 && w < 40) begin
            @(negedge clk); #1;
            w++;
        end
    endtask

    task automatic job(input int i, input logic [127:0] d, input logic [255:0] k, input logic [1:0] s,
                       input logic [127:0] exp, input string tag);
        logic [N-1:0] oh;
        int lat;
        oh  = N'(1) << i;
        lat = (s == 2'd3) ? 1 : LAT + 1;
        set_req(i, d, k, s);
        bus.req_valid[i] = 1'b1;
        #1;
        wait_ready(i);
        chk({tag, "_ready"}, bus.req_ready, oh);
        @(negedge clk);
        bus.req_valid[i] = 1'b0;
        for (int c = 1; c < lat; c++) begin
            chk({tag, "_busy_rv"}, bus.resp_valid, '0);
            @(negedge clk);
        end
        chk({tag, "_rv"}, bus.resp_valid, oh);
        chk({tag, "_data"}, bus.resp_data, exp);
        chk({tag, "_err"}, bus.resp_err, s == 2'd3);
        if (s != 2'd3) begin
            chk({tag, "_core_in"}, core_in, d);
            chk({tag, "_core_ksel"}, core_ksel, s);
        end
        bus.resp_ready = oh;
        @(negedge clk);
        bus.resp_ready = '0;
        chk({tag, "_rv_drop"}, bus.resp_valid, '0);
        chk({tag, "_err_drop"}, bus.resp_err, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, bus.req_ready, '0);
        chk({tag, "_resp_valid"}, bus.resp_valid, '0);
        chk({tag, "_resp_err"}, bus.resp_err, 1'b0);
        chk({tag, "_resp_data"}, bus.resp_data, '0);
        chk({tag, "_core_in"}, core_in, '0);
        chk({tag, "_core_key"}, core_key, '0);
        chk({tag, "_core_ksel"}, core_ksel, '0);
    endtask

    initial begin
        logic [127:0] pts [N];
        logic [255:0] keys[N];
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_data = '0;
        bus.req_key = '0;
        bus.req_ksel = '0;
        bus.resp_ready = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        job(0, PT, {128'b0, K128}, 2'd0, CT128, "aes128");
        job(1, PT, {64'b0, K192},  2'd1, CT192, "aes192");
        job(2, PT, K256,           2'd2, CT256, "aes256");

        job(3, 128'hdead_beef, 256'h1234, 2'd3, '0, "illegal");
        chk("illegal_core_in", core_in, PT);
        chk("illegal_core_key", core_key, K256);
        chk("illegal_core_ksel", core_ksel, 2'd2);

        for (int i = 0; i < N; i++) begin
            pts[i]  = {4{32'(i + 1)}};
            keys[i] = {8{32'(i * 7 + 3)}};
            set_req(i, pts[i], keys[i], 2'd0);
        end
        rst = 1'b1;
        bus.req_valid = '1;
        bus.resp_ready = '1;
        repeat (2) @(negedge clk);
        chk("rr_ready_in_reset", bus.req_ready, '0);
        rst = 1'b0;
        #1;
        for (int j = 0; j < 6; j++) begin
            logic [N-1:0] oh;
            oh = N'(1) << (j % N);
            wait_any;
            chk("rr_grant", bus.req_ready, oh);
            @(negedge clk);
            if (j == 5) bus.req_valid = '0;
            chk("rr_core_in", core_in, pts[j % N]);
            repeat (LAT) @(negedge clk);
            chk("rr_rv", bus.resp_valid, oh);
            chk("rr_data", bus.resp_data, core_model(pts[j % N], keys[j % N], 2'd0));
            @(negedge clk); #1;
        end
        bus.resp_ready = '0;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        set_req(0, PT, {128'b0, K128}, 2'd0);
        set_req(1, PT, {64'b0, K192}, 2'd1);
        set_req(2, PT, K256, 2'd2);
        bus.req_valid = 4'b0111;
        bus.resp_ready = 4'b1110;
        #1;
        chk("hold_grant", bus.req_ready, 4'b0001);
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        repeat (LAT) @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            chk("hold_rv", bus.resp_valid, 4'b0001);
            chk("hold_data", bus.resp_data, CT128);
            chk("hold_no_accept", bus.req_ready, '0);
            @(negedge clk);
        end
        bus.resp_ready = 4'b0001;
        #1;
        chk("hs_rv", bus.resp_valid, 4'b0001);
        chk("hs_no_accept", bus.req_ready, '0);
        @(negedge clk);
        bus.resp_ready = '0;
        chk("after_hs_grant", bus.req_ready, 4'b0010);
        chk("after_hs_data_kept", bus.resp_data, CT128);

        @(negedge clk);
        rst = 1'b1;
        bus.req_valid = '0;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        rst = 1'b0;
        bus.resp_ready = '1;
        repeat (LAT + 2) begin
            @(negedge clk);
            chk("dropped_job_rv", bus.resp_valid, '0);
        end
        bus.resp_ready = '0;
        set_req(3, 128'h77, 256'h88, 2'd0);
        bus.req_valid = 4'b1000;
        job(0, PT, {128'b0, K128}, 2'd0, CT128, "post_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
